// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator (I/S/B/U/J, optional Z via IMM_GEN_ZICSR_EN) with tag sideband.
// Latency 1 cycle; 2-entry skid buffer, in_ready is a registered function of buffer state only.
module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [2:0]       in_imm_src,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_err
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [XLEN-1:0]  out_imm_q, out_imm_d, skid_imm_q, skid_imm_d;
   logic [TAG_W-1:0] out_tag_q, out_tag_d, skid_tag_q, skid_tag_d;
   logic             out_err_q, out_err_d, skid_err_q, skid_err_d;

   logic [31:0]      raw_imm;
   logic             new_err;
   logic [XLEN-1:0]  new_imm;
   logic             accept;
   logic             unused_opcode;

   // Opcode bits never feed an immediate.
   assign unused_opcode = ^in_instr[6:0];

   always_comb begin
      raw_imm = '0;
      new_err = 1'b0;
      case (in_imm_src)
         3'b000: raw_imm = {{20{in_instr[31]}}, in_instr[31:20]};
         3'b001: raw_imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         3'b010: raw_imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                            in_instr[30:25], in_instr[11:8], 1'b0};
         3'b011: raw_imm = {in_instr[31:12], 12'b0};
         3'b100: raw_imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                            in_instr[20], in_instr[30:21], 1'b0};
`ifdef IMM_GEN_ZICSR_EN
         3'b101: raw_imm = {27'b0, in_instr[19:15]};
`endif
         default: new_err = 1'b1;
      endcase
   end

   // Every format is already 32-bit sign-correct (Z has bit 31 clear), so one sign extension covers XLEN=64.
   assign new_imm = XLEN'($signed(raw_imm));

   assign in_ready  = (state_q != FULL);
   assign out_valid = (state_q != EMPTY);
   assign accept    = in_valid && in_ready;

   always_comb begin
      state_d    = state_q;
      out_imm_d  = out_imm_q;
      out_tag_d  = out_tag_q;
      out_err_d  = out_err_q;
      skid_imm_d = skid_imm_q;
      skid_tag_d = skid_tag_q;
      skid_err_d = skid_err_q;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_d   = ONE;
                  out_imm_d = new_imm;
                  out_tag_d = in_tag;
                  out_err_d = new_err;
               end
            end
            ONE: begin
               if (accept && out_ready) begin
                  out_imm_d = new_imm;
                  out_tag_d = in_tag;
                  out_err_d = new_err;
               end else if (accept) begin
                  state_d    = FULL;
                  skid_imm_d = new_imm;
                  skid_tag_d = in_tag;
                  skid_err_d = new_err;
               end else if (out_ready) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (out_ready) begin
                  state_d   = ONE;
                  out_imm_d = skid_imm_q;
                  out_tag_d = skid_tag_q;
                  out_err_d = skid_err_q;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= EMPTY;
         out_imm_q  <= '0;
         out_tag_q  <= '0;
         out_err_q  <= 1'b0;
         skid_imm_q <= '0;
         skid_tag_q <= '0;
         skid_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         out_imm_q  <= out_imm_d;
         out_tag_q  <= out_tag_d;
         out_err_q  <= out_err_d;
         skid_imm_q <= skid_imm_d;
         skid_tag_q <= skid_tag_d;
         skid_err_q <= skid_err_d;
      end
   end

   assign out_imm = out_imm_q;
   assign out_tag = out_tag_q;
   assign out_err = out_err_q;

endmodule
